shared_reg_arbiter: RTL and testbench



---
 rtl/shared_reg_arbiter_pkg.sv | 15 +
 rtl/shared_reg_arbiter_if.sv | 30 +++
 rtl/shared_reg_arbiter_rr_pick.sv | 33 +++
 rtl/shared_reg_arbiter.sv | 88 ++++++++
 tb/tb_shared_reg_arbiter.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/shared_reg_arbiter_pkg.sv
// Shared types and helpers for the shared-register arbiter and its pieces.
package shared_reg_arbiter_pkg;

    // Sequencer state: IDLE when nothing was written last cycle, OWNED otherwise.
    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    // Width of a requester index; never narrower than one bit.
    function automatic int idx_width(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/shared_reg_arbiter_if.sv
// Bundle between the producer blocks and the shared-register arbiter.
interface shared_reg_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) ();
    import shared_reg_arbiter_pkg::*;

    localparam int IW = idx_width(NREQ);

    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       lock;
    logic [NREQ*WIDTH-1:0] wdata;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       ack;
    logic [WIDTH-1:0]      q;
    logic [IW-1:0]         owner;
    logic                  valid;

    // Producer side: drives requests and data, observes the register.
    modport master (
        output req, lock, wdata,
        input  gnt, ack, q, owner, valid
    );

    // Arbiter side.
    modport slave (
        input  req, lock, wdata,
        output gnt, ack, q, owner, valid
    );
endinterface

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit scanning from ptr
// upward with wrap-around. Reusable by any arbiter with a rotating pointer.
module rr_pick
    import shared_reg_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [IW-1:0]   winner,
    output logic            any_req
);

    // Scan NREQ positions starting at ptr; the first hit wins.
    always_comb begin
        int  idx;
        logic found;
        // NOTE: every combinational output gets a default before any branch, otherwise a path that skips the assignment infers a latch.
        winner  = '0;
        found   = 1'b0;
        any_req = |req;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req[idx]) begin
                winner = IW'(idx);
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter and sequencer for one shared register with per-requester
// ownership locking of up to MAX_HOLD consecutive writes.
module shared_reg_arbiter
    import shared_reg_arbiter_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    shared_reg_arbiter_if.slave  bus
);

    localparam int IW  = idx_width(NREQ);
    localparam int HCW = $clog2(MAX_HOLD) + 1;
    localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

    state_t         state, state_nxt;
    logic [IW-1:0]  ptr, ptr_nxt;
    logic [IW-1:0]  pick_idx, win_idx;
    logic [HCW-1:0] hold_cnt, hold_nxt;
    logic           pick_any, hold_hit, do_grant;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req     (bus.req),
        .ptr     (ptr),
        .winner  (pick_idx),
        .any_req (pick_any)
    );

    // Next-state: hold the current owner, else round-robin, else go idle.
    always_comb begin
        state_nxt = IDLE;
        ptr_nxt   = ptr;
        hold_nxt  = hold_cnt;
        win_idx   = bus.owner;
        do_grant  = 1'b0;
        hold_hit  = (state == OWNED) && bus.req[bus.owner] && bus.lock[bus.owner]
                    && (hold_cnt < HCW'(MAX_HOLD - 1));
        if (hold_hit) begin
            state_nxt = OWNED;
            hold_nxt  = hold_cnt + 1'b1;
            do_grant  = 1'b1;
        end else if (pick_any) begin
            state_nxt = OWNED;
            win_idx   = pick_idx;
            hold_nxt  = '0;
            ptr_nxt   = (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
            do_grant  = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of block order.
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Pointer, hold counter and the shared register with its grant outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: q is reset as well because owner/valid/gnt describe it; a pure data store would normally be left unreset.
            ptr       <= '0;
            hold_cnt  <= '0;
            bus.q     <= '0;
            bus.gnt   <= '0;
            bus.ack   <= '0;
            bus.owner <= '0;
            bus.valid <= 1'b0;
        end else begin
            ptr      <= ptr_nxt;
            hold_cnt <= hold_nxt;
            if (do_grant) begin
                bus.q     <= bus.wdata[win_idx*WIDTH +: WIDTH];
                bus.gnt   <= ONE_HOT0 << win_idx;
                bus.ack   <= ONE_HOT0 << win_idx;
                bus.owner <= win_idx;
                bus.valid <= 1'b1;
            end else begin
                bus.gnt <= '0;
                bus.ack <= '0;
            end
        end
    end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Self-checking bench: directed steps followed by randomized traffic, compared
// each cycle against a behavioural model of the grant rules.
module tb_shared_reg_arbiter;

    localparam int NREQ     = 4;
    localparam int WIDTH    = 8;
    localparam int MAX_HOLD = 4;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    // Model state: last grant, rotating start, length of the current run.
    logic [WIDTH-1:0] m_q;
    logic [NREQ-1:0]  m_gnt;
    int               m_owner, m_ptr, m_run;
    logic             m_valid, m_granted;

    shared_reg_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bif ();

    shared_reg_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Predict the outcome of the coming edge, apply it, then compare.
    task automatic tick();
        int  win;
        bit  hold;
        if (reset) begin
            m_q = '0; m_gnt = '0; m_owner = 0; m_valid = 1'b0;
            m_ptr = 0; m_run = 0; m_granted = 1'b0;
        end else begin
            win  = -1;
            hold = m_granted && bif.req[m_owner] && bif.lock[m_owner] && (m_run < MAX_HOLD);
            if (hold) begin
                win = m_owner;
                m_run++;
            end else if (bif.req != '0) begin
                for (int k = 0; k < NREQ; k++)
                    if (win < 0 && bif.req[(m_ptr + k) % NREQ]) win = (m_ptr + k) % NREQ;
                m_run = 1;
                m_ptr = (win + 1) % NREQ;
            end
            if (win >= 0) begin
                m_q = bif.wdata[win*WIDTH +: WIDTH];
                m_gnt = '0;
                m_gnt[win] = 1'b1;
                m_owner = win;
                m_valid = 1'b1;
                m_granted = 1'b1;
            end else begin
                m_gnt = '0;
                m_granted = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        chk("gnt",    32'(bif.gnt),   32'(m_gnt));
        chk("ack",    32'(bif.ack),   32'(m_gnt));
        chk("q",      32'(bif.q),     32'(m_q));
        chk("owner",  32'(bif.owner), 32'(m_owner));
        chk("valid",  32'(bif.valid), 32'(m_valid));
        chk("ack_1h", 32'($countones(bif.ack) <= 1), 32'd1);
    endtask

    task automatic set_data(input int base);
        for (int i = 0; i < NREQ; i++) bif.wdata[i*WIDTH +: WIDTH] = WIDTH'(base + i);
    endtask

    initial begin
        int exp_seq[10];
        exp_seq = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

        // Reset with every requester active.
        reset = 1'b1; bif.req = 4'b1111; bif.lock = '0; set_data(8'h40);
        tick();
        tick();
        chk("rst_gnt",   32'(bif.gnt), 32'd0);
        chk("rst_valid", 32'(bif.valid), 32'd0);

        // Single write, then requester drops.
        reset = 1'b0; bif.req = 4'b0001; bif.wdata[0 +: WIDTH] = 8'hA5;
        tick();
        chk("single_q",   32'(bif.q),   32'hA5);
        chk("single_ack", 32'(bif.ack), 32'b0001);
        bif.req = '0;
        tick();
        chk("idle_gnt", 32'(bif.gnt), 32'd0);
        chk("idle_q",   32'(bif.q),   32'hA5);

        // Round-robin over all four from reset.
        reset = 1'b1; tick(); reset = 1'b0;
        bif.req = 4'b1111; set_data(8'h10);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("rr_owner", 32'(bif.owner), 32'(k % NREQ));
            chk("rr_q",     32'(bif.q),     32'(8'h10 + (k % NREQ)));
        end

        // Locking requester 0 against requester 1.
        reset = 1'b1; bif.req = '0; tick(); reset = 1'b0;
        bif.req = 4'b0011; bif.lock = 4'b0001;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("lock_seq", 32'(bif.owner), 32'(exp_seq[k]));
        end

        // Wrap-around of the pointer.
        reset = 1'b1; bif.lock = '0; tick(); reset = 1'b0;
        bif.req = 4'b0100; tick();
        chk("wrap_a", 32'(bif.owner), 32'd2);
        bif.req = 4'b1001; tick();
        chk("wrap_b", 32'(bif.owner), 32'd3);
        tick();
        chk("wrap_c", 32'(bif.owner), 32'd0);

        // Reset in the middle of a locked burst.
        reset = 1'b1; tick(); reset = 1'b0;
        bif.req = 4'b0001; bif.lock = 4'b0001;
        tick();
        tick();
        reset = 1'b1; tick();
        chk("midlock_gnt",   32'(bif.gnt),   32'd0);
        chk("midlock_q",     32'(bif.q),     32'd0);
        chk("midlock_valid", 32'(bif.valid), 32'd0);
        reset = 1'b0; bif.req = 4'b0010; bif.lock = 4'b0010; bif.wdata[WIDTH +: WIDTH] = 8'h5C;
        for (int k = 0; k < MAX_HOLD + 1; k++) begin
            tick();
            chk("relock_owner", 32'(bif.owner), 32'd1);
        end
        chk("relock_q", 32'(bif.q), 32'h5C);

        // Randomized traffic with occasional reset.
        for (int c = 0; c < 400; c++) begin
            reset    = ($urandom_range(0, 39) == 0);
            bif.req  = NREQ'($urandom_range(0, 15));
            bif.lock = NREQ'($urandom_range(0, 15));
            bif.wdata = (NREQ*WIDTH)'($urandom);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
